// File: rtl/x_stage_mc_pkg.sv
// Shared types for the multi-cycle execute stage: opcodes, FSM states, divide-by-zero quotient.
package x_stage_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MULT  = 4'd10,
    OP_MULTU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_MFHI  = 4'd14,
    OP_MFLO  = 4'd15
  } exec_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } x_state_t;

  localparam int unsigned X_MAX_W = 128;
  localparam logic [X_MAX_W-1:0] X_DIV0_Q = '1;

  function automatic logic is_multi_cycle(exec_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/x_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO; one bit per cycle.
module x_muldiv_iter
  import x_stage_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0]   cnt;
  logic               div_q, neg_q, rem_neg_q, div0_q;
  logic [WIDTH-1:0]   m, acc_hi, acc_lo;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] mul_next, prod;
  logic [WIDTH-1:0]   div_hi_n, div_lo_n, quo, rem;

  // Operate on magnitudes; signs are reapplied on the final step.
  always_comb begin
    sa    = is_signed & a[WIDTH-1];
    sb    = is_signed & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One iteration of both algorithms; m is the multiplicand or the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    mul_next = {mul_sum, acc_lo[WIDTH-1:1]};
    prod     = neg_q ? -mul_next : mul_next;
    trial    = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, m};
    div_hi_n = trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : trial[WIDTH-1:0];
    div_lo_n = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
    quo      = div0_q ? X_DIV0_Q[WIDTH-1:0] : (neg_q ? -div_lo_n : div_lo_n);
    rem      = rem_neg_q ? -div_hi_n : div_hi_n;
  end

  assign done_c = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      cnt       <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      m         <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      hi        <= '0;
      lo        <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= '0;
      div_q     <= is_div;
      neg_q     <= sa ^ sb;
      rem_neg_q <= sa;
      div0_q    <= is_div && (b == '0);
      m         <= is_div ? mag_b : mag_a;
      acc_hi    <= '0;
      acc_lo    <= is_div ? mag_a : mag_b;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
      if (div_q) begin
        acc_hi <= div_hi_n;
        acc_lo <= div_lo_n;
      end else begin
        {acc_hi, acc_lo} <= mul_next;
      end
      if (done_c) begin
        busy <= 1'b0;
        if (div_q) begin
          hi <= rem;
          lo <= quo;
        end else begin
          {hi, lo} <= prod;
        end
      end
    end
  end

endmodule

// File: rtl/x_stage_mc.sv
// Registered execute stage with valid/ready handshakes and an iterative mul/div unit.
// Optional operand forwarding ports are enabled by defining X_FWD_BYPASS_EN.
module x_stage_mc
  import x_stage_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_alu_src,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_rt,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [4:0]       in_rd_addr,
`ifdef X_FWD_BYPASS_EN
  input  logic             fwd_a_en,
  input  logic             fwd_b_en,
  input  logic [WIDTH-1:0] fwd_data,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_pc_branch,
  output logic [WIDTH-1:0] out_rt,
  output logic [4:0]       out_dst_addr,
  output logic             busy
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  x_state_t         state, state_n;
  exec_op_t         op;
  logic [WIDTH-1:0] op_a, rt_eff, op_b, alu_res, md_hi, md_lo;
  logic [SH_W-1:0]  shamt;
  logic             accept, multi, op_div, op_signed, md_start_c, md_done_c;

  assign op = exec_op_t'(in_op);

`ifdef X_FWD_BYPASS_EN
  assign op_a   = fwd_a_en ? fwd_data : in_rs;
  assign rt_eff = fwd_b_en ? fwd_data : in_rt;
`else
  assign op_a   = in_rs;
  assign rt_eff = in_rt;
`endif

  assign op_b      = in_alu_src ? in_imm : rt_eff;
  assign shamt     = op_b[SH_W-1:0];
  assign multi     = is_multi_cycle(op);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in_ready  = !reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = WIDTH'(op_a < op_b);
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(op_a) >>> shamt);
      OP_MFHI: alu_res = md_hi;
      OP_MFLO: alu_res = md_lo;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    md_start_c = 1'b0;
    case (state)
      IDLE: begin
        if (accept && multi) begin
          md_start_c = 1'b1;
          state_n    = op_div ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        if (md_done_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  x_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start_c),
    .is_div    (op_div),
    .is_signed (op_signed),
    .a         (op_a),
    .b         (op_b),
    .done_c    (md_done_c),
    .busy      (busy),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  // Sideband fields load at accept; a mul/div only raises out_valid when it completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_pc_branch <= '0;
      out_rt        <= '0;
      out_dst_addr  <= '0;
    end else if (accept) begin
      out_valid     <= !multi;
      out_result    <= alu_res;
      out_pc_branch <= in_pc + in_imm + WIDTH'(1);
      out_rt        <= rt_eff;
      out_dst_addr  <= in_rd_addr;
    end else if (md_done_c) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_zero = (out_result == '0);

endmodule

// File: tb/tb_x_stage_mc.sv
// Directed bench for x_stage_mc: spec-level model with scoreboard plus literal expectations.
module tb_x_stage_mc;
  import x_stage_mc_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, in_alu_src;
  logic [3:0]   in_op;
  logic [W-1:0] in_rs, in_rt, in_imm, in_pc;
  logic [4:0]   in_rd_addr;
  logic         out_valid, out_ready, out_zero, busy;
  logic [W-1:0] out_result, out_pc_branch, out_rt;
  logic [4:0]   out_dst_addr;

  always #5 clk = ~clk;

  x_stage_mc #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_alu_src    (in_alu_src),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .in_imm        (in_imm),
    .in_pc         (in_pc),
    .in_rd_addr    (in_rd_addr),
`ifdef X_FWD_BYPASS_EN
    .fwd_a_en      (1'b0),
    .fwd_b_en      (1'b0),
    .fwd_data      ('0),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_pc_branch (out_pc_branch),
    .out_rt        (out_rt),
    .out_dst_addr  (out_dst_addr),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] res, pcb, rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    case (op)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = p;
      end
      OP_MULTU: {m_hi, m_lo} = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 32'h0; end
        else begin m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b); end
      end
      OP_DIVU: begin
        if (b == 32'h0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  // Accept monitor: record what each transferred instruction must produce.
  initial forever begin : monitor
    exp_t        e;
    logic [31:0] b;
    @(posedge clk);
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      sb.delete();
    end else if (in_valid && in_ready) begin
      b     = in_alu_src ? in_imm : in_rt;
      e.pcb = in_pc + in_imm + 32'd1;
      e.rt  = in_rt;
      e.rd  = in_rd_addr;
      e.res = is_multi_cycle(exec_op_t'(in_op)) ? 32'd0 : alu_model(in_op, in_rs, b);
      md_model(in_op, in_rs, b);
      sb.push_back(e);
    end
  end

  // Output compare: every downstream transfer must match the oldest pending instruction.
  initial forever begin : compare
    exp_t e;
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_spurious: output transfer result 0x%0h with nothing pending", out_result);
      end else begin
        e = sb.pop_front();
        check("sb_result", out_result, e.res);
        check("sb_zero", 32'(out_zero), 32'(e.res == 32'd0));
        check("sb_pc_branch", out_pc_branch, e.pcb);
        check("sb_rt", out_rt, e.rt);
        check("sb_dst", 32'(out_dst_addr), 32'(e.rd));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [3:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd);
    bit acc = 1'b0;
    in_op = op; in_alu_src = src; in_rs = a; in_rt = b; in_imm = imm; in_pc = pc;
    in_rd_addr = rd; in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: in_ready got 0, want 1");
    end
  endtask

  // Returns the 1-based negedge count at which out_valid appears (0 on timeout).
  task automatic wait_out(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (out_valid) begin cyc = i; break; end
      if (busy && !in_ready) busy_cyc++;
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expv, input string name);
    int cyc, bc;
    issue(op, 1'b0, a, b, 32'h0, 32'h0, 5'd1);
    wait_out(cyc, bc);
    check(name, out_result, expv);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [31:0] a, b, imm, e;
  } vec_t;

  function automatic vec_t mk(logic [3:0] op, logic src, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic [31:0] e);
    vec_t v;
    v.op = op; v.src = src; v.a = a; v.b = b; v.imm = imm; v.e = e;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[12];
    int   cyc, bc, stalls, stable;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_op = '0; in_alu_src = 1'b0;
    in_rs = '0; in_rt = '0; in_imm = '0; in_pc = '0; in_rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_pc_branch", out_pc_branch, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD with branch target, then SUB to zero with wrapping target
    issue(OP_ADD, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'h100, 5'd3);
    @(negedge clk);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", out_result, 32'd12);
    check("add_zero", 32'(out_zero), 32'd0);
    check("branch_target", out_pc_branch, 32'h0000_00FF);
    @(posedge clk); #1;
    issue(OP_SUB, 1'b0, 32'd7, 32'd7, 32'h0, 32'hFFFF_FFFF, 5'd4);
    @(negedge clk);
    check("sub_result", out_result, 32'd0);
    check("sub_zero", 32'(out_zero), 32'd1);
    check("branch_wrap", out_pc_branch, 32'd0);
    @(posedge clk); #1;

    // MULT -3 * 4: latency and stall window
    issue(OP_MULT, 1'b0, 32'hFFFF_FFFD, 32'd4, 32'h0, 32'h0, 5'd0);
    wait_out(cyc, bc);
    check("mult_busy_cycles", 32'(bc), 32'd32);
    check("mult_latency", 32'(cyc), 32'd33);
    check("mult_result", out_result, 32'd0);
    @(posedge clk); #1;
    run(OP_MFLO, 0, 0, 32'hFFFF_FFF4, "mflo_mult");
    run(OP_MFHI, 0, 0, 32'hFFFF_FFFF, "mfhi_mult");

    // Divides, including divide by zero and MIN / -1
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, "div_result");
    run(OP_MFLO, 0, 0, 32'hFFFF_FFFD, "mflo_div");
    run(OP_MFHI, 0, 0, 32'hFFFF_FFFF, "mfhi_div");
    run(OP_DIVU, 32'd9, 32'd0, 32'd0, "divu0_result");
    run(OP_MFLO, 0, 0, 32'hFFFF_FFFF, "mflo_div0");
    run(OP_MFHI, 0, 0, 32'd9, "mfhi_div0");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "div_min_result");
    run(OP_MFLO, 0, 0, 32'h8000_0000, "mflo_min");
    run(OP_MFHI, 0, 0, 32'd0, "mfhi_min");
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "multu_result");
    run(OP_MFHI, 0, 0, 32'hFFFF_FFFE, "mfhi_multu");
    run(OP_MFLO, 0, 0, 32'd1, "mflo_multu");

    // Back-to-back single-cycle table
    tbl[0]  = mk(OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1);
    tbl[1]  = mk(OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0);
    tbl[2]  = mk(OP_SLL,  1'b0, 32'd1, 32'd31, 32'h0, 32'h8000_0000);
    tbl[3]  = mk(OP_SRL,  1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'h0800_0000);
    tbl[4]  = mk(OP_SRA,  1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000);
    tbl[5]  = mk(OP_AND,  1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_F000);
    tbl[6]  = mk(OP_OR,   1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_FFF0);
    tbl[7]  = mk(OP_XOR,  1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_0FF0);
    tbl[8]  = mk(OP_ADD,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0);
    tbl[9]  = mk(OP_SUB,  1'b0, 32'd0, 32'd1, 32'h0, 32'hFFFF_FFFF);
    tbl[10] = mk(OP_ADD,  1'b1, 32'd10, 32'd999, 32'hFFFF_FFFB, 32'd5);
    tbl[11] = mk(OP_SLL,  1'b0, 32'd1, 32'd33, 32'h0, 32'd2);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      in_op = tbl[i].op; in_alu_src = tbl[i].src; in_rs = tbl[i].a; in_rt = tbl[i].b;
      in_imm = tbl[i].imm; in_pc = 32'(i); in_rd_addr = 5'(i); in_valid = 1'b1;
      @(negedge clk);
      if (i > 0) check($sformatf("b2b_%0d", i - 1), out_result, tbl[i-1].e);
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_11", out_result, tbl[11].e);
    check("b2b_stalls", 32'(stalls), 32'd0);
    @(posedge clk); #1;

    // Backpressure for 3 cycles after an ADD
    issue(OP_ADD, 1'b0, 32'd100, 32'd23, 32'h0, 32'h40, 5'd5);
    out_ready = 1'b0;
    in_op = OP_ADD; in_alu_src = 1'b0; in_rs = 32'd1; in_rt = 32'd2; in_rd_addr = 5'd6;
    in_valid = 1'b1;
    stable = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid && out_result == 32'd123 && out_dst_addr == 5'd5 && !in_ready) stable++;
      @(posedge clk); #1;
    end
    check("bp_stable", 32'(stable), 32'd3);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_result", out_result, 32'd3);
    check("bp_next_dst", 32'(out_dst_addr), 32'd6);
    @(posedge clk); #1;

    // Reset at cycle 10 of a MULTU aborts it; HI/LO return to zero
    issue(OP_MULTU, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0, 5'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    run(OP_MFHI, 0, 0, 32'd0, "mfhi_after_abort");
    run(OP_MFLO, 0, 0, 32'd0, "mflo_after_abort");

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/x_stage_mc.md
Name: x_stage_mc

Overview:
- Parametrised, registered execute stage for the single-issue pipeline; successor to the combinational execute stage.
- Adds valid/ready handshakes on both sides and an output pipeline register.
- Adds an iterative multi-cycle multiply/divide unit with HI/LO registers.
- Sits between decode/register-read and memory stage; stalls upstream while a multi-cycle op runs.

Parameters:
- WIDTH, 32, datapath width in bits (>=8, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- in_op  in  4  exec_op_t operation
- in_alu_src  in  1  1 = operand B is imm, 0 = rt
- in_rs  in  WIDTH  operand A
- in_rt  in  WIDTH  operand B / store data
- in_imm  in  WIDTH  sign-extended immediate
- in_pc  in  WIDTH  instruction PC (word address)
- in_rd_addr  in  5  destination register
- out_valid  out  1  result registered and valid
- out_ready  in  1  downstream accepts
- out_result  out  WIDTH  ALU / MFHI / MFLO result
- out_zero  out  1  out_result == 0
- out_pc_branch  out  WIDTH  in_pc + in_imm + 1, mod 2^WIDTH
- out_rt  out  WIDTH  registered in_rt
- out_dst_addr  out  5  registered in_rd_addr
- busy  out  1  multi-cycle op in progress

Behaviour:
- Operand B = in_alu_src ? in_imm : in_rt.
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR: arithmetic wraps mod 2^WIDTH.
  - SLT (signed), SLTU: result is 0 or 1.
  - SLL, SRL, SRA: shift amount is B[$clog2(WIDTH)-1:0].
  - MFHI, MFLO: return the HI or LO register.
- Multi-cycle ops: MULT, MULTU, DIV, DIVU. These write HI/LO only; out_result = 0.
- Handshake:
  - Transfer occurs when valid && ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_* hold stable while out_valid && !out_ready.
- FSM states IDLE, MUL, DIV:
  - IDLE plus accepted single-cycle op: output register loads; out_valid=1 next cycle (latency 1).
  - IDLE plus accepted MULT/MULTU: latch magnitudes and sign flags; cnt=0; go to MUL. busy=1.
  - MUL: shift-add, one bit per cycle. When cnt==WIDTH-1: apply sign correction, write {HI,LO} = 2*WIDTH-bit product, load output register, return to IDLE.
  - DIV: restoring, one quotient bit per cycle, same exit rule. LO = quotient, HI = remainder.
  - Signed remainder takes the sign of the dividend.
  - Total latency for MUL/DIV is WIDTH+1 cycles from accept to out_valid.
- Divide by zero: LO = all ones, HI = dividend.
- Signed MIN / -1: LO = MIN, HI = 0. No trap.
- Hazards:
  - in_ready=0 while busy, so MFHI/MFLO always see the completed HI/LO.
  - Back-to-back single-cycle ops sustain 1 per cycle when out_ready=1.
- Reset:
  - out_valid=0, busy=0, state=IDLE, HI=LO=0, all out_* data=0, in_ready=0 during reset.
  - Reset mid-MUL/DIV aborts the op; no HI/LO write.
- out_zero is computed from the registered out_result.

Optional Feature:
- X_FWD_BYPASS_EN defined:
  - Adds ports fwd_a_en, fwd_b_en (in, 1) and fwd_data (in, WIDTH).
  - When set, fwd_data replaces in_rs (fwd_a_en) or in_rt (fwd_b_en) before operand selection, in the accept cycle only.
- Undefined: no ports; operands are taken directly.

Decomposition:
- Package definitions:
  - exec_op_t enum with the 16 encodings: ADD=0, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, MULT, MULTU, DIV, DIVU, MFHI, MFLO=15.
  - x_state_t enum {IDLE, MUL, DIV}.
  - X_DIV0_Q constant (all ones).
- One natural sub-module, x_muldiv_iter: owns the counter, partial product/remainder, HI/LO and sign fix-up. It exposes start/done/busy to the stage FSM.

Test Plan:
- After reset, ADD rs=5, rt=7, alu_src=0 -> next cycle out_valid=1, out_result=12, out_zero=0. SUB 7-7 -> out_result=0, out_zero=1.
- Issue MULT rs=-3, rt=4 (WIDTH=32), then MFLO and MFHI:
  - in_ready=0 and busy=1 for 32 cycles; out_valid at cycle 33.
  - MFLO=0xFFFFFFF4, MFHI=0xFFFFFFFF.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- Backpressure: out_ready=0 for 3 cycles after an ADD.
  - out_* stay stable and in_ready=0.
  - The next ADD is accepted the cycle after out_ready rises.
  - No instruction is lost or duplicated (scoreboard).
- Assert reset at cycle 10 of a MULT -> next cycle busy=0, out_valid=0; a subsequent MFHI returns 0.
- Branch target: in_pc=0x100, in_imm=0xFFFFFFFE -> out_pc_branch=0xFF. Wrap case: in_pc=0xFFFFFFFF, imm=0 -> 0.
